// File: rtl/event_scheduler.sv
// Timed event dispatcher: pops {data, lt} entries from the event FIFO in order and releases
// each one once cur_time reaches lt. Optional late-entry dropping via EVENT_SCHED_LATE_DROP_EN.
module event_scheduler #(
  parameter int DATA_W     = 16,
  parameter int TIME_W     = 16,
  parameter int DROP_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fifo_empty,
  input  logic [DATA_W+TIME_W-1:0] fifo_data,
  output logic                     fifo_dequeue,
  input  logic                     tick,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TIME_W-1:0]        out_time,
  output logic [TIME_W-1:0]        cur_time,
  output logic                     busy,
  output logic [DROP_CNT_W-1:0]    drop_count
);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    WAIT,
    SEND
  } state_t;

  state_t state;
  state_t next_state;

  logic [DATA_W-1:0] hold_data;
  logic [TIME_W-1:0] hold_lt;
  logic [TIME_W-1:0] time_diff;
  logic              due;

  // Serial-number compare: the entry is due while cur_time is at most half the ring ahead of lt.
  assign time_diff = cur_time - hold_lt;
  assign due       = ~time_diff[TIME_W-1];

`ifdef EVENT_SCHED_LATE_DROP_EN
  logic late;
  logic drop_inc;

  assign late = due && (hold_lt != cur_time);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data <= '0;
      hold_lt   <= '0;
    end else if (state == LOAD) begin
      hold_data <= fifo_data[DATA_W+TIME_W-1:TIME_W];
      hold_lt   <= fifo_data[TIME_W-1:0];
    end
  end

  // Free-running timestep counter, independent of the dispatcher state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_time <= '0;
    end else if (tick) begin
      cur_time <= cur_time + TIME_W'(1);
    end
  end

  always_comb begin
    next_state = state;
`ifdef EVENT_SCHED_LATE_DROP_EN
    drop_inc   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          next_state = POP;
        end
      end
      POP:  next_state = LOAD;
      LOAD: next_state = WAIT;
      WAIT: begin
`ifdef EVENT_SCHED_LATE_DROP_EN
        if (late) begin
          next_state = IDLE;
          drop_inc   = 1'b1;
        end else if (due) begin
          next_state = SEND;
        end
`else
        if (due) begin
          next_state = SEND;
        end
`endif
      end
      SEND: begin
        if (out_ready) begin
          next_state = fifo_empty ? IDLE : POP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef EVENT_SCHED_LATE_DROP_EN
  // Saturating count of late entries discarded in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (drop_inc && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end
`else
  assign drop_count = '0;
`endif

  assign fifo_dequeue = (state == POP);
  assign out_valid    = (state == SEND);
  assign busy         = (state != IDLE);
  assign out_data     = hold_data;
  assign out_time     = hold_lt;

endmodule

// File: doc/event_scheduler.md
# event_scheduler

Timed event dispatcher directly downstream of the event FIFO. Pops `{data, lt}` entries from the FIFO, holds each until the global timestep counter reaches its `lt` field, then presents the payload on a valid/ready output port to the neuron update stage. Runs one entry at a time, in FIFO order. No reordering: a late-timestamped head blocks younger entries.

## Interface
- `DATA_W`, 16, payload width; occupies FIFO word bits `[DATA_W+TIME_W-1:TIME_W]`
- `TIME_W`, 16, timestamp and counter width; occupies FIFO word bits `[TIME_W-1:0]`
- `DROP_CNT_W`, 8, width of the late-drop counter

- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_data`  in  DATA_W+TIME_W  FIFO `data_out`; updates on the edge that samples `fifo_dequeue`=1 with the FIFO non-empty
- `fifo_dequeue`  out  1  one-cycle pop request to the FIFO
- `tick`  in  1  single-cycle pulse; advances the timestep counter
- `out_valid`  out  1  payload available
- `out_ready`  in  1  consumer accepts
- `out_data`  out  DATA_W  payload of the held entry
- `out_time`  out  TIME_W  `lt` of the held entry
- `cur_time`  out  TIME_W  current timestep
- `busy`  out  1  state is not IDLE
- `drop_count`  out  DROP_CNT_W  late entries discarded (feature-dependent)

## Operation
- FSM states: IDLE, POP, LOAD, WAIT, SEND.
- **IDLE:** if `!fifo_empty`, go to POP.
- **POP:** `fifo_dequeue`=1 for exactly this cycle. Then go to LOAD.
- **LOAD:** capture `fifo_data` into the hold registers `hold_data` and `hold_lt`. Then go to WAIT.
- **WAIT:** entry is due when `(cur_time - hold_lt) mod 2^TIME_W < 2^(TIME_W-1)` (serial-number compare, wrap-safe).
  - If due, go to SEND.
  - Otherwise stay in WAIT.
- **SEND:** `out_valid`=1, with `out_data`=`hold_data` and `out_time`=`hold_lt` held stable until `out_ready`.
  - On handshake (`out_valid & out_ready`) with `!fifo_empty`, go straight to POP.
  - On handshake with the FIFO empty, go to IDLE.
- **Timestep counter:** `cur_time` increments by 1 on each clock with `tick`=1, wrapping `2^TIME_W-1` to 0.
  - Compares use the registered (pre-increment) value.
  - A tick and a compare in the same cycle therefore see the old time.
- **Payload rule:** `out_data`/`out_time` are driven from the hold registers in every state. They carry meaning only while `out_valid`=1.
- **Late entry:** due with `hold_lt != cur_time`, i.e. `lt` strictly in the past.

## Timing
- **Reset values:** `fifo_dequeue`=0, `out_valid`=0, `out_data`=0, `out_time`=0, `cur_time`=0, `busy`=0, `drop_count`=0, state IDLE.
- **Reset mid-operation:** an entry already popped and held is lost. No dequeue is issued while reset is asserted.
- **Pop latency:** FIFO non-empty in IDLE → `fifo_dequeue` next cycle → `out_valid` no earlier than 3 cycles after leaving IDLE (POP, LOAD, WAIT, then SEND).
- **Back-to-back throughput:** with a non-empty FIFO and entries already due, one output every 4 cycles.
- **No over-pop:** `fifo_dequeue` is never asserted while `fifo_empty`=1, and never twice for one entry.
- **Stalled consumer:** `out_ready` low holds the FSM in SEND indefinitely. `cur_time` keeps advancing.
- **Counter stalls:** `tick` does not depend on FSM state. The counter never stalls.

## Configuration
- `EVENT_SCHED_LATE_DROP_EN`
  - **Defined:** in WAIT, a late entry is discarded and the FSM goes to IDLE without asserting `out_valid`. `drop_count` increments and saturates at `2^DROP_CNT_W-1`. Entries with `lt == cur_time` are still dispatched.
  - **Undefined:** late entries are dispatched like on-time ones. `drop_count` is tied to 0.

## Test plan
- **Reset:** assert `reset`=0 mid-WAIT holding `{10,5}` with `cur_time`=3 → all outputs at reset values immediately. After release, `fifo_dequeue` is asserted only if `!fifo_empty`.
- **In-order dispatch:** `cur_time`=1, FIFO holds `{10,1}`, `{11,1}`, `{12,1}`, `out_ready`=1 → outputs 10, 11, 12 with `out_time`=1. Exactly 3 dequeue pulses. `out_valid` spaced 4 cycles apart.
- **Wait for time:** `cur_time`=0, FIFO holds `{11,4}` → held in WAIT. `out_valid` rises only after the 4th tick has registered (`cur_time`=4). `{12,2}` queued behind it follows immediately after, not before.
- **Backpressure:** `out_ready`=0 for 20 cycles while `{7,0}` is due → `out_valid` stays 1 with `out_data`=7 stable. No further `fifo_dequeue`. One transfer when `out_ready` rises.
- **Wrap-around:** `cur_time`=0xFFFE, entry `lt`=0x0001 → not due at 0xFFFE or 0xFFFF, due after the tick to 0x0001.
- **Late-drop feature:** `cur_time`=9, entry `{3,5}`.
  - With `EVENT_SCHED_LATE_DROP_EN`: no `out_valid`, `drop_count`=1.
  - Without it: `out_data`=3 with `out_time`=5 dispatched, `drop_count`=0.
